// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags.
// Hands out up to two new tags per cycle to rename, takes back up to two
// retired Told tags per cycle, and on a mispredict flush rewinds the
// allocation pointer to the retire pointer so every speculatively
// allocated tag becomes free again.
module free_list #(
  parameter int NUM_AR   = 32,
  parameter int NUM_PR   = 64,
  parameter int FL_DEPTH = NUM_PR - NUM_AR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] id_dispatch_num,
  input  logic       id_valid_inst0,
  input  logic       id_valid_inst1,
  input  logic [1:0] rob_retire_num,
  input  logic       rob_retire_valid0,
  input  logic       rob_retire_valid1,
  input  logic [6:0] rob_told0,
  input  logic [6:0] rob_told1,
  input  logic       rob_mispredict,
  output logic [6:0] fl_pr0,
  output logic [6:0] fl_pr1,
  output logic [1:0] fl_avail,
  output logic [5:0] fl_free_count,
  output logic       fl_error
);

  localparam int PTR_W = $clog2(FL_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Tag storage and pointers
  logic [6:0]       entries_q [FL_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] rhead_q, rhead_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;

  // Per-cycle decode
  logic             allocSlot0, allocSlot1;
  logic             freeSlot0, freeSlot1;
  logic [1:0]       allocReq, allocEff;
  logic [1:0]       freeReq, freeEff;
  logic             underflow, overflow;
  logic [CNT_W:0]   countSum;
  logic             wrEn0, wrEn1;
  logic [PTR_W-1:0] wrIdx0, wrIdx1;
  logic [PTR_W-1:0] headPlusOne;

  // Decode requests, detect under/overflow and compute next pointer state
  always_comb begin
    allocSlot0 = (id_dispatch_num >= 2'd1) && id_valid_inst0;
    allocSlot1 = (id_dispatch_num == 2'd2) && id_valid_inst1;
    freeSlot0  = (rob_retire_num >= 2'd1) && rob_retire_valid0;
    freeSlot1  = (rob_retire_num == 2'd2) && rob_retire_valid1;
    allocReq   = 2'(allocSlot0) + 2'(allocSlot1);
    freeReq    = 2'(freeSlot0) + 2'(freeSlot1);

    // A flush ignores same-cycle dispatch, so it can never underflow
    underflow  = !rob_mispredict && ({{(CNT_W-2){1'b0}}, allocReq} > count_q);
    allocEff   = (rob_mispredict || underflow) ? 2'd0 : allocReq;

    countSum   = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, freeReq}
               - {{(CNT_W-1){1'b0}}, allocEff};
    overflow   = countSum > (CNT_W+1)'(FL_DEPTH);
    freeEff    = overflow ? 2'd0 : freeReq;

    wrEn0      = freeSlot0 && !overflow;
    wrEn1      = freeSlot1 && !overflow;
    wrIdx0     = tail_q;
    wrIdx1     = tail_q + PTR_W'(freeSlot0);

    tail_d     = tail_q + PTR_W'(freeEff);
    rhead_d    = rhead_q + PTR_W'(freeEff);
    if (rob_mispredict) begin
      head_d  = rhead_q + PTR_W'(freeEff);
      count_d = CNT_W'(FL_DEPTH);
    end else begin
      head_d  = head_q + PTR_W'(allocEff);
      count_d = count_q + CNT_W'(freeEff) - CNT_W'(allocEff);
    end
    error_d    = error_q || underflow || overflow;
    headPlusOne = head_q + PTR_W'(1);
  end

  // Tag storage: reset to the non-architectural tags, then write Told tags at tail
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entries_q[i] <= 7'(NUM_AR + i);
      end
    end else begin
      if (wrEn0) entries_q[wrIdx0] <= rob_told0;
      if (wrEn1) entries_q[wrIdx1] <= rob_told1;
    end
  end

  // Pointer, count and sticky error registers
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      rhead_q <= '0;
      count_q <= CNT_W'(FL_DEPTH);
      error_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      rhead_q <= rhead_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Outputs come straight from registered state; slot 1 takes the head tag when slot 0 is idle
  always_comb begin
    fl_pr0        = entries_q[head_q];
    fl_pr1        = id_valid_inst0 ? entries_q[headPlusOne] : entries_q[head_q];
    fl_avail      = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
    fl_free_count = count_q;
    fl_error      = error_q;
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed bench for free_list with a queue-based reference model.
// The model tracks the free tags and the in-flight (allocated, not yet retired)
// tags as ordered queues; a flush puts the in-flight tags back in front of the
// free queue.
module tb_free_list;

  logic       clock;
  logic       reset;
  logic [1:0] id_dispatch_num;
  logic       id_valid_inst0;
  logic       id_valid_inst1;
  logic [1:0] rob_retire_num;
  logic       rob_retire_valid0;
  logic       rob_retire_valid1;
  logic [6:0] rob_told0;
  logic [6:0] rob_told1;
  logic       rob_mispredict;
  logic [6:0] fl_pr0;
  logic [6:0] fl_pr1;
  logic [1:0] fl_avail;
  logic [5:0] fl_free_count;
  logic       fl_error;

  int checks = 0;
  int errors = 0;

  logic [6:0] freeQ[$];
  logic [6:0] inflightQ[$];
  bit         modelErr = 0;
  bit         modelValid = 0;

  free_list dut (
    .clock(clock),
    .reset(reset),
    .id_dispatch_num(id_dispatch_num),
    .id_valid_inst0(id_valid_inst0),
    .id_valid_inst1(id_valid_inst1),
    .rob_retire_num(rob_retire_num),
    .rob_retire_valid0(rob_retire_valid0),
    .rob_retire_valid1(rob_retire_valid1),
    .rob_told0(rob_told0),
    .rob_told1(rob_told1),
    .rob_mispredict(rob_mispredict),
    .fl_pr0(fl_pr0),
    .fl_pr1(fl_pr1),
    .fl_avail(fl_avail),
    .fl_free_count(fl_free_count),
    .fl_error(fl_error)
  );

  // Free-running clock
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idleInputs();
    id_dispatch_num   = 0;
    id_valid_inst0    = 0;
    id_valid_inst1    = 0;
    rob_retire_num    = 0;
    rob_retire_valid0 = 0;
    rob_retire_valid1 = 0;
    rob_told0         = 0;
    rob_told1         = 0;
    rob_mispredict    = 0;
  endtask

  task automatic applyStimulus(input int dn, input bit v0, input bit v1,
                               input int rn, input bit rv0, input bit rv1,
                               input int t0, input int t1, input bit mp);
    id_dispatch_num   = 2'(dn);
    id_valid_inst0    = v0;
    id_valid_inst1    = v1;
    rob_retire_num    = 2'(rn);
    rob_retire_valid0 = rv0;
    rob_retire_valid1 = rv1;
    rob_told0         = 7'(t0);
    rob_told1         = 7'(t1);
    rob_mispredict    = mp;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idleInputs();
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
  endtask

  // Reference model: advance the free/in-flight queues on each rising edge
  always @(posedge clock) begin : modelUpdate
    int na;
    logic [6:0] tolds[$];
    if (reset) begin
      freeQ = {};
      for (int i = 0; i < 32; i++) freeQ.push_back(7'(32 + i));
      inflightQ = {};
      modelErr = 0;
      modelValid = 1;
    end else begin
      na = 0;
      if (id_dispatch_num >= 1 && id_valid_inst0) na++;
      if (id_dispatch_num == 2 && id_valid_inst1) na++;
      tolds = {};
      if (rob_retire_num >= 1 && rob_retire_valid0) tolds.push_back(rob_told0);
      if (rob_retire_num == 2 && rob_retire_valid1) tolds.push_back(rob_told1);
      if (rob_mispredict) na = 0;
      if (na > freeQ.size()) begin
        modelErr = 1;
        na = 0;
      end
      if (freeQ.size() + tolds.size() - na > 32) begin
        modelErr = 1;
        tolds = {};
      end
      repeat (na) inflightQ.push_back(freeQ.pop_front());
      foreach (tolds[k]) begin
        if (inflightQ.size() > 0) void'(inflightQ.pop_front());
        freeQ.push_back(tolds[k]);
      end
      if (rob_mispredict) begin
        while (inflightQ.size() > 0) freeQ.push_front(inflightQ.pop_back());
      end
    end
  end

  // Compare DUT outputs with the model mid-cycle
  always @(negedge clock) begin : compare
    int sz;
    if (modelValid && !reset) begin
      sz = freeQ.size();
      checkOutput("free_count", int'(fl_free_count), sz);
      checkOutput("avail", int'(fl_avail), (sz >= 2) ? 2 : sz);
      checkOutput("error", int'(fl_error), int'(modelErr));
      if (sz >= 1) checkOutput("pr0", int'(fl_pr0), int'(freeQ[0]));
      if (id_valid_inst0) begin
        if (sz >= 2) checkOutput("pr1", int'(fl_pr1), int'(freeQ[1]));
      end else if (sz >= 1) begin
        checkOutput("pr1", int'(fl_pr1), int'(freeQ[0]));
      end
    end
  end

  // Directed test sequence
  initial begin
    reset = 1;
    idleInputs();
    doReset();
    checkOutput("reset_count", int'(fl_free_count), 32);
    checkOutput("reset_avail", int'(fl_avail), 2);
    checkOutput("reset_error", int'(fl_error), 0);
    checkOutput("reset_pr0", int'(fl_pr0), 32);

    // Three double dispatches
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("dual_pr0", int'(fl_pr0), 32 + 2 * k);
      checkOutput("dual_pr1", int'(fl_pr1), 33 + 2 * k);
      tick();
    end
    checkOutput("dual_count", int'(fl_free_count), 26);

    // Slot 0 idle: slot 1 takes the head tag
    applyStimulus(2, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("slot1_pr0", int'(fl_pr0), 38);
    checkOutput("slot1_pr1", int'(fl_pr1), 38);
    tick();
    checkOutput("slot1_count", int'(fl_free_count), 25);
    checkOutput("slot1_next_pr0", int'(fl_pr0), 39);

    // Drain to one entry, then underflow
    repeat (12) begin
      applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    checkOutput("drain_count", int'(fl_free_count), 1);
    checkOutput("drain_avail", int'(fl_avail), 1);
    checkOutput("drain_pr0", int'(fl_pr0), 63);
    applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("under_count", int'(fl_free_count), 1);
    checkOutput("under_error", int'(fl_error), 1);
    checkOutput("under_pr0", int'(fl_pr0), 63);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("empty_count", int'(fl_free_count), 0);
    checkOutput("empty_avail", int'(fl_avail), 0);

    // Empty: retire two while dispatching one
    applyStimulus(1, 1, 0, 2, 1, 1, 5, 7, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("refill_pr0", int'(fl_pr0), 5);
    checkOutput("refill_pr1", int'(fl_pr1), 7);
    checkOutput("refill_count", int'(fl_free_count), 2);

    // Wrap: 40 tags through the FIFO
    doReset();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 0, (i > 0) ? 1 : 0, i > 0, 0, i, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 1, 1, 0, 40, 0, 0);
    tick();
    checkOutput("wrap_count", int'(fl_free_count), 32);
    checkOutput("wrap_error", int'(fl_error), 0);
    checkOutput("wrap_pr0", int'(fl_pr0), 9);

    // Mispredict recovery
    doReset();
    repeat (3) begin
      applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 2, 1, 1, 3, 4, 0);
    tick();
    checkOutput("pre_flush_count", int'(fl_free_count), 28);
    applyStimulus(2, 1, 1, 1, 1, 0, 9, 0, 1);
    tick();
    checkOutput("flush_count", int'(fl_free_count), 32);
    checkOutput("flush_pr0", int'(fl_pr0), 35);
    checkOutput("flush_error", int'(fl_error), 0);
    repeat (14) begin
      applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("flush_tail_count", int'(fl_free_count), 3);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_tail_pr0", int'(fl_pr0), 3);
    checkOutput("flush_tail_pr1", int'(fl_pr1), 4);
    applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("flush_last_pr0", int'(fl_pr0), 9);

    // Overflow: free into a full list
    doReset();
    applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 0);
    tick();
    checkOutput("over_error", int'(fl_error), 1);
    checkOutput("over_count", int'(fl_free_count), 32);
    checkOutput("over_pr0", int'(fl_pr0), 32);

    // Reset mid-operation
    applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    doReset();
    checkOutput("rst_count", int'(fl_free_count), 32);
    checkOutput("rst_pr0", int'(fl_pr0), 32);
    checkOutput("rst_error", int'(fl_error), 0);
    @(negedge clock);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
